// File: rtl/shim_mon_pkg.sv
// shim_mon_pkg: shared channel constants, scan state encoding and concat unpack helper
package shim_mon_pkg;
  localparam int NUM_CH = 8;
  localparam int ABS_W = 15;
  typedef enum logic {IDLE, SCAN} state_e;
  function automatic logic [ABS_W-1:0] unpack_abs(input logic [NUM_CH*ABS_W-1:0] concat, input int ch);
    return concat[ch*ABS_W +: ABS_W];
  endfunction
endpackage

// File: rtl/shim_current_limit_monitor_if.sv
// shim_current_limit_monitor_if: DAC value feed, control pulses and fault outputs of the monitor
interface shim_current_limit_monitor_if;
  import shim_mon_pkg::*;
  logic                    enable;
  logic                    ldac;
  logic [NUM_CH*ABS_W-1:0] abs_dac_val_concat;
  logic                    clear_faults;
  logic [NUM_CH-1:0]       inst_fault_mask;
  logic [NUM_CH-1:0]       integ_fault_mask;
  logic                    shutdown_req;
  logic                    scan_busy;
  modport master (
    output enable, ldac, abs_dac_val_concat, clear_faults,
    input  inst_fault_mask, integ_fault_mask, shutdown_req, scan_busy
  );
  modport slave (
    input  enable, ldac, abs_dac_val_concat, clear_faults,
    output inst_fault_mask, integ_fault_mask, shutdown_req, scan_busy
  );
endinterface

// File: rtl/leaky_integ_step.sv
// leaky_integ_step: one saturating leaky-integrator update plus threshold compare
module leaky_integ_step import shim_mon_pkg::*; #(
  parameter int ACC_W = 24,
  parameter int LEAK_SHIFT = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ABS_W-1:0] abs_val,
  input  logic [ACC_W-1:0] limit,
  output logic [ACC_W-1:0] acc_next,
  output logic             over
);
  logic [ACC_W:0] sum;
  always_comb begin
    sum = {1'b0, acc - (acc >> LEAK_SHIFT)} + (ACC_W+1)'(abs_val);
    acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    over = acc_next > limit;
  end
endmodule

// File: rtl/shim_current_limit_monitor.sv
// shim_current_limit_monitor: per-channel instantaneous and I^2t-style limit monitor
module shim_current_limit_monitor import shim_mon_pkg::*; #(
  parameter logic [ABS_W-1:0] INST_LIMIT = 15'd30000,
  parameter int LEAK_SHIFT = 8,
  parameter int unsigned INTEG_LIMIT = 6000000,
  parameter logic [15:0] SAMPLE_PERIOD = 16'd1000
) (
  input logic clk,
  input logic resetn,
  shim_current_limit_monitor_if.slave bus
);
  localparam int ACC_W = 16 + LEAK_SHIFT;
  localparam logic [ACC_W-1:0] ACC_LIM = ACC_W'(INTEG_LIMIT);
  logic              ldac_q, ldac_d, chk_q, chk_d, shut_q, shut_d, tick, over, scan;
  logic [ABS_W-1:0]  snap_q [NUM_CH];
  logic [ABS_W-1:0]  snap_d [NUM_CH];
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W-1:0]  acc_step;
  logic [15:0]       cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic [2:0]        ch_idx_q, ch_idx_d;
  logic [NUM_CH-1:0] inst_q, inst_d, integ_q, integ_d, inst_set, integ_set;
  // single shared integrator datapath, steered by the scan index
  leaky_integ_step #(.ACC_W(ACC_W), .LEAK_SHIFT(LEAK_SHIFT)) u_step (
    .acc(acc_q[ch_idx_q]),
    .abs_val(snap_q[ch_idx_q]),
    .limit(ACC_LIM),
    .acc_next(acc_step),
    .over(over)
  );
  always_comb begin
    tick = cnt_q == '0;
    cnt_d = tick ? SAMPLE_PERIOD - 16'd1 : cnt_q - 16'd1;
    ldac_d = bus.ldac;
    chk_d = ldac_q;
    scan = state_q == SCAN;
    state_d = scan ? (ch_idx_q == 3'(NUM_CH-1) ? IDLE : SCAN) : (tick ? SCAN : IDLE);
    ch_idx_d = scan ? ch_idx_q + 3'd1 : '0;
    inst_set = '0;
    integ_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      snap_d[i] = ldac_q ? unpack_abs(bus.abs_dac_val_concat, i) : snap_q[i];
      inst_set[i] = chk_q && bus.enable && snap_q[i] > INST_LIMIT;
      acc_d[i] = !bus.enable ? '0 : (scan && ch_idx_q == 3'(i)) ? acc_step : acc_q[i];
      integ_set[i] = scan && ch_idx_q == 3'(i) && bus.enable && over;
    end
    inst_d = (bus.clear_faults ? '0 : inst_q) | inst_set;
    integ_d = (bus.clear_faults ? '0 : integ_q) | integ_set;
    shut_d = |{inst_q, integ_q};
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ldac_q <= 1'b0;
      chk_q <= 1'b0;
      snap_q <= '{default: '0};
      acc_q <= '{default: '0};
      cnt_q <= '0;
      state_q <= IDLE;
      ch_idx_q <= '0;
      inst_q <= '0;
      integ_q <= '0;
      shut_q <= 1'b0;
    end else begin
      ldac_q <= ldac_d;
      chk_q <= chk_d;
      snap_q <= snap_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      ch_idx_q <= ch_idx_d;
      inst_q <= inst_d;
      integ_q <= integ_d;
      shut_q <= shut_d;
    end
  end
  assign bus.inst_fault_mask = inst_q;
  assign bus.integ_fault_mask = integ_q;
  assign bus.shutdown_req = shut_q;
  assign bus.scan_busy = state_q == SCAN;
endmodule

// File: tb/tb_shim_current_limit_monitor.sv
// tb_shim_current_limit_monitor: cycle-keyed scoreboard bench for the current limit monitor
module tb_shim_current_limit_monitor;
  localparam int S_INST = 0, S_INTEG = 1, S_SHUT = 2, S_BUSY = 3, S_ACC0 = 4, S_ACC5 = 5, S_IDX = 6, S_ANY = 7;
  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int cyc = 0;
  int total = 0;
  int passed = 0;
  int r = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] got;
  shim_current_limit_monitor_if bus();
  shim_current_limit_monitor #(.SAMPLE_PERIOD(16'd16)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] obs(input int sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      S_INST:  v = 32'(bus.inst_fault_mask);
      S_INTEG: v = 32'(bus.integ_fault_mask);
      S_SHUT:  v = 32'(bus.shutdown_req);
      S_BUSY:  v = 32'(bus.scan_busy);
      S_ACC0:  v = 32'(dut.acc_q[0]);
      S_ACC5:  v = 32'(dut.acc_q[5]);
      S_IDX:   v = 32'(dut.ch_idx_q);
      default: for (int i = 0; i < 8; i++) if (dut.acc_q[i] != '0) v = 32'd1;
    endcase
    return v;
  endfunction
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      got = obs(e.sel);
      total++;
      if (e.cyc != cyc || got !== e.val)
        $display("FAIL %s @cycle %0d (seen %0d): got %0h expected %0h", e.name, e.cyc, cyc, got, e.val);
      else
        passed++;
    end
  end
  task automatic expect_at(input int c, input string nm, input int sel, input logic [31:0] v);
    exp_t x;
    int i;
    x = '{c, nm, sel, v};
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, x);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask
  function automatic logic [119:0] all(input logic [14:0] v);
    logic [119:0] c;
    for (int i = 0; i < 8; i++) c[15*i +: 15] = v;
    return c;
  endfunction
  function automatic logic [119:0] put(input logic [119:0] c, input int ch, input logic [14:0] v);
    logic [119:0] o;
    o = c;
    o[15*ch +: 15] = v;
    return o;
  endfunction
  task automatic ldac_pulse(input logic [119:0] c);
    bus.abs_dac_val_concat = c;
    bus.ldac = 1'b1;
    step();
    bus.ldac = 1'b0;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    bus.ldac = 1'b0;
    bus.clear_faults = 1'b0;
    bus.enable = 1'b1;
    bus.abs_dac_val_concat = '0;
    step();
    step();
    r = cyc;
    expect_at(r, "rst_inst", S_INST, 0);
    expect_at(r, "rst_integ", S_INTEG, 0);
    expect_at(r, "rst_shut", S_SHUT, 0);
    expect_at(r, "rst_busy", S_BUSY, 0);
    expect_at(r, "rst_idx", S_IDX, 0);
    resetn = 1'b1;
  endtask
  initial begin
    longint a;
    int n;
    int guard;
    // inst fault on ch3 just above limit, plus scan_busy timing
    do_reset();
    expect_at(r + 2, "t1_inst_early", S_INST, 0);
    expect_at(r + 3, "t1_inst", S_INST, 32'h08);
    expect_at(r + 3, "t1_shut_lag", S_SHUT, 0);
    expect_at(r + 4, "t1_shut", S_SHUT, 1);
    expect_at(r + 1, "t1_busy_first", S_BUSY, 1);
    expect_at(r + 8, "t1_busy_last", S_BUSY, 1);
    expect_at(r + 9, "t1_busy_done", S_BUSY, 0);
    expect_at(r + 17, "t1_busy_next", S_BUSY, 1);
    ldac_pulse(put(all(15'd100), 3, 15'd30001));
    wait_until(r + 20);
    // equality does not fault; acc0 after the first scan using the snapshot
    do_reset();
    expect_at(r + 3, "t2_inst_eq", S_INST, 0);
    expect_at(r + 4, "t2_shut_eq", S_SHUT, 0);
    expect_at(r + 18, "t2_acc0_1", S_ACC0, 30000);
    expect_at(r + 34, "t2_acc0_2", S_ACC0, 59883);
    ldac_pulse(put(all(15'd0), 0, 15'd30000));
    wait_until(r + 36);
    // full-scale ch5 until the integrator trips
    do_reset();
    a = 0;
    n = 0;
    while (n < 2000) begin
      a = a - (a >> 8) + 32767;
      if (a > 6000000) break;
      n++;
    end
    expect_at(r + 3, "t3_inst", S_INST, 32'h20);
    expect_at(r + 7 + 16 * (n - 1), "t3_integ_prev", S_INTEG, 0);
    expect_at(r + 7 + 16 * n, "t3_integ_trip", S_INTEG, 32'h20);
    expect_at(r + 7 + 16 * n, "t3_acc5", S_ACC5, 32'(a));
    ldac_pulse(put(all(15'd0), 5, 15'd32767));
    wait_until(r + 8 + 16 * n);
    // steady 20000 on every channel stays below the integrator limit
    do_reset();
    a = 0;
    for (int s = 0; s < 1000; s++) a = a - (a >> 8) + 20000;
    expect_at(r + 3, "t4_inst", S_INST, 0);
    expect_at(r + 16 * 999, "t4_busy_pre", S_BUSY, 0);
    expect_at(r + 1 + 16 * 999, "t4_busy_on", S_BUSY, 1);
    expect_at(r + 8 + 16 * 999, "t4_busy_end", S_BUSY, 1);
    expect_at(r + 9 + 16 * 999, "t4_busy_off", S_BUSY, 0);
    expect_at(r + 2 + 16 * 1000, "t4_acc0", S_ACC0, 32'(a));
    expect_at(r + 10 + 16 * 1000, "t4_integ", S_INTEG, 0);
    expect_at(r + 10 + 16 * 1000, "t4_shut", S_SHUT, 0);
    ldac_pulse(all(15'd20000));
    wait_until(r + 12 + 16 * 1000);
    // clear_faults with condition gone, then coincident with a new set
    do_reset();
    expect_at(r + 2, "t5_inst_early", S_INST, 0);
    expect_at(r + 3, "t5_inst_set", S_INST, 32'h04);
    expect_at(r + 6, "t5_inst_hold", S_INST, 32'h04);
    expect_at(r + 7, "t5_inst_clr", S_INST, 0);
    expect_at(r + 7, "t5_shut_hold", S_SHUT, 1);
    expect_at(r + 8, "t5_shut_clr", S_SHUT, 0);
    expect_at(r + 11, "t5_inst_two", S_INST, 32'h44);
    expect_at(r + 13, "t5_inst_pre", S_INST, 32'h44);
    expect_at(r + 14, "t5_inst_setwins", S_INST, 32'h40);
    ldac_pulse(put(all(15'd0), 2, 15'd30500));
    wait_until(r + 3);
    ldac_pulse(put(all(15'd0), 2, 15'd100));
    wait_until(r + 6);
    bus.clear_faults = 1'b1;
    step();
    bus.clear_faults = 1'b0;
    wait_until(r + 8);
    ldac_pulse(put(put(all(15'd0), 2, 15'd30500), 6, 15'd31000));
    wait_until(r + 11);
    ldac_pulse(put(put(all(15'd0), 2, 15'd100), 6, 15'd31000));
    wait_until(r + 13);
    bus.clear_faults = 1'b1;
    step();
    bus.clear_faults = 1'b0;
    wait_until(r + 16);
    // enable low mid-scan, then reset mid-scan
    do_reset();
    expect_at(r + 3, "t6_inst_all", S_INST, 32'hff);
    expect_at(r + 36, "t6_acc_live", S_ANY, 1);
    expect_at(r + 37, "t6_acc_zero", S_ANY, 0);
    expect_at(r + 38, "t6_acc_zero2", S_ANY, 0);
    expect_at(r + 39, "t6_inst_clr", S_INST, 0);
    expect_at(r + 41, "t6_shut_clr", S_SHUT, 0);
    expect_at(r + 43, "t6_inst_dis", S_INST, 0);
    expect_at(r + 43, "t6_integ_dis", S_INTEG, 0);
    expect_at(r + 46, "t6_inst_reen", S_INST, 32'hff);
    expect_at(r + 47, "t6_shut_reen", S_SHUT, 1);
    expect_at(r + 52, "t6_busy_mid", S_BUSY, 1);
    expect_at(r + 52, "t6_idx_mid", S_IDX, 3);
    expect_at(r + 52, "t6_acc_mid", S_ANY, 1);
    expect_at(r + 53, "t6_busy_rst", S_BUSY, 0);
    expect_at(r + 53, "t6_idx_rst", S_IDX, 0);
    expect_at(r + 53, "t6_inst_rst", S_INST, 0);
    expect_at(r + 53, "t6_integ_rst", S_INTEG, 0);
    expect_at(r + 53, "t6_shut_rst", S_SHUT, 0);
    expect_at(r + 53, "t6_acc_rst", S_ANY, 0);
    ldac_pulse(all(15'd32767));
    wait_until(r + 36);
    bus.enable = 1'b0;
    wait_until(r + 38);
    bus.clear_faults = 1'b1;
    step();
    bus.clear_faults = 1'b0;
    ldac_pulse(all(15'd32767));
    wait_until(r + 43);
    bus.enable = 1'b1;
    ldac_pulse(all(15'd32767));
    wait_until(r + 52);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      step();
      guard++;
    end
    step();
    if (sb.size() != 0) begin
      total += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
